// File: rtl/boruss_cpu_datapath.sv
// Execution datapath behind the CPU control FSM: 4x8 register file, ALU and flag register.
// The result and flags are registered in EXECUTE; the register file is written in WRITEBACK.
module boruss_cpu_datapath #(
    parameter logic [2:0] EXEC_STATE    = 3'b010,
    parameter logic [2:0] WB_STATE      = 3'b011,
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] current_state,
    input  logic [3:0] opcode,
    input  logic [1:0] dest_reg,
    input  logic [1:0] src_reg,
    input  logic       is_immediate,
    input  logic [7:0] immediate_value,
    input  logic       update_registers,
    output logic [7:0] alu_result,
    output logic       alu_zero_flag,
    output logic       alu_carry_flag,
    output logic       alu_negative_flag,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data,
    output logic       reg_write
);

    typedef enum logic [3:0] {
        OP_MOV = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_CMP = 4'hF
    } op_e;

    logic [7:0] regs [0:3];
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] res;
    logic       carry;
    logic       alu_en;
    logic       wr_en;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        op_a   = regs[dest_reg];
        op_b   = is_immediate ? immediate_value : regs[src_reg];
        res    = 8'h00;
        carry  = 1'b0;
        alu_en = 1'b1;
        case (opcode)
            OP_MOV:         res = op_b;
            OP_ADD:         {carry, res} = {1'b0, op_a} + {1'b0, op_b};
            // Bit 8 of the 9-bit difference is the borrow, i.e. A < B.
            OP_SUB, OP_CMP: {carry, res} = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:         res = op_a & op_b;
            OP_OR:          res = op_a | op_b;
            OP_XOR:         res = op_a ^ op_b;
            OP_SHL: begin
                res   = {op_a[6:0], 1'b0};
                carry = op_a[7];
            end
            OP_SHR: begin
                res   = {1'b0, op_a[7:1]};
                carry = op_a[0];
            end
            default:        alu_en = 1'b0;
        endcase
    end

    // Jumps and CMP (opcodes 8..F) never touch the register file.
    assign wr_en     = (current_state == WB_STATE) && update_registers && !opcode[3];
    assign reg_write = wr_en && reset;
    assign dbg_data  = regs[dbg_sel];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result        <= 8'h00;
            alu_zero_flag     <= 1'b0;
            alu_carry_flag    <= 1'b0;
            alu_negative_flag <= 1'b0;
        end else if (current_state == EXEC_STATE && alu_en) begin
            alu_result        <= res;
            alu_zero_flag     <= (res == 8'h00);
            alu_carry_flag    <= carry;
            alu_negative_flag <= res[7];
        end
    end

    // NOTE: the register file is only four bytes, so it is reset like ordinary flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= REG_RESET_VAL;
        end else if (wr_en) begin
            regs[dest_reg] <= alu_result;
        end
    end

endmodule

// File: tb/tb_boruss_cpu_datapath.sv
// Self-checking bench for boruss_cpu_datapath: directed test-plan sequence plus randomized
// instruction streams, compared every cycle against an arithmetic reference model.
module tb_boruss_cpu_datapath;

    localparam logic [2:0] ST_FETCH = 3'b000;
    localparam logic [2:0] ST_DEC   = 3'b001;
    localparam logic [2:0] ST_EXEC  = 3'b010;
    localparam logic [2:0] ST_WB    = 3'b011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] current_state = ST_FETCH;
    logic [3:0] opcode = 4'h0;
    logic [1:0] dest_reg = 2'd0;
    logic [1:0] src_reg = 2'd0;
    logic       is_immediate = 1'b0;
    logic [7:0] immediate_value = 8'h00;
    logic       update_registers = 1'b0;
    logic [7:0] alu_result;
    logic       alu_zero_flag;
    logic       alu_carry_flag;
    logic       alu_negative_flag;
    logic [1:0] dbg_sel = 2'd0;
    logic [7:0] dbg_data;
    logic       reg_write;

    boruss_cpu_datapath dut (
        .clk(clk),
        .reset(reset),
        .current_state(current_state),
        .opcode(opcode),
        .dest_reg(dest_reg),
        .src_reg(src_reg),
        .is_immediate(is_immediate),
        .immediate_value(immediate_value),
        .update_registers(update_registers),
        .alu_result(alu_result),
        .alu_zero_flag(alu_zero_flag),
        .alu_carry_flag(alu_carry_flag),
        .alu_negative_flag(alu_negative_flag),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data),
        .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rw_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    int m_regs [4];
    int m_alu;
    bit m_z, m_c, m_n;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_flags();
        return {5'b0, alu_zero_flag, alu_carry_flag, alu_negative_flag};
    endfunction

    function automatic logic [7:0] flags(input bit z, input bit c, input bit n);
        return {5'b0, z, c, n};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_alu = 0;
        m_z = 0;
        m_c = 0;
        m_n = 0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        int a, b, r;
        bit c;
        int op;
        op = int'(opcode);
        if (current_state == ST_WB && update_registers && op < 8)
            m_regs[dest_reg] = m_alu;
        if (current_state == ST_EXEC && (op < 8 || op == 15)) begin
            a = m_regs[dest_reg];
            b = is_immediate ? int'(immediate_value) : m_regs[src_reg];
            c = 0;
            case (op)
                0: r = b;
                1: begin r = (a + b) % 256; c = (a + b) > 255; end
                2, 15: begin r = (a - b + 256) % 256; c = a < b; end
                3: r = a & b;
                4: r = a | b;
                5: r = a ^ b;
                6: begin r = (a * 2) % 256; c = a >= 128; end
                default: begin r = a / 2; c = (a % 2) == 1; end
            endcase
            m_alu = r;
            m_z = (r == 0);
            m_c = c;
            m_n = (r >= 128);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("alu_result", alu_result, 8'(m_alu));
            check("flags_zcn", dut_flags(), flags(m_z, m_c, m_n));
            check("reg_write", {7'b0, reg_write},
                  {7'b0, (current_state == ST_WB && update_registers && opcode <= 4'h7)});
            check("dbg_data", dbg_data, 8'(m_regs[dbg_sel]));
            if (reg_write) rw_cnt++;
        end
    end

    task automatic step(input logic [2:0] st, input logic [3:0] op, input logic [1:0] d,
                        input logic [1:0] s, input logic im, input logic [7:0] iv,
                        input logic up);
        current_state    = st;
        opcode           = op;
        dest_reg         = d;
        src_reg          = s;
        is_immediate     = im;
        immediate_value  = iv;
        update_registers = up;
        dbg_sel          = 2'($urandom);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic im, input logic [7:0] iv, input logic up);
        step(ST_FETCH, 4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        step(ST_DEC, op, d, s, im, iv, 1'($urandom));
        step(ST_EXEC, op, d, s, im, iv, 1'($urandom));
        step(ST_WB, op, d, s, im, iv, up);
    endtask

    task automatic rd(input logic [1:0] idx, output logic [7:0] val);
        dbg_sel = idx;
        #1;
        val = dbg_data;
    endtask

    logic [7:0] v;
    int rw0;

    initial begin
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            check("reset_reg", v, 8'h00);
        end
        check("reset_flags", dut_flags(), 8'h00);
        check("reset_rw", {7'b0, reg_write}, 8'h00);

        // MOV R1, #F0
        rw0 = rw_cnt;
        instr(4'h0, 2'd1, 2'd0, 1'b1, 8'hF0, 1'b1);
        check("mov_res", alu_result, 8'hF0);
        check("mov_flags", dut_flags(), flags(0, 0, 1));
        check("mov_rw_pulses", 8'(rw_cnt - rw0), 8'd1);
        rd(2'd1, v);
        check("mov_r1", v, 8'hF0);

        // MOV R2, #20 ; ADD R1, R2
        instr(4'h0, 2'd2, 2'd0, 1'b1, 8'h20, 1'b1);
        instr(4'h1, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1);
        check("add_res", alu_result, 8'h10);
        check("add_flags", dut_flags(), flags(0, 1, 0));
        rd(2'd1, v);
        check("add_r1", v, 8'h10);

        // SUB R2, R2 ; SUB R2, #01
        instr(4'h2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b1);
        check("sub_zero_res", alu_result, 8'h00);
        check("sub_zero_flags", dut_flags(), flags(1, 0, 0));
        instr(4'h2, 2'd2, 2'd0, 1'b1, 8'h01, 1'b1);
        check("sub_borrow_res", alu_result, 8'hFF);
        check("sub_borrow_flags", dut_flags(), flags(0, 1, 1));

        // MOV R2, #10 ; CMP R1, R2 with write strobe ; JZ
        instr(4'h0, 2'd2, 2'd0, 1'b1, 8'h10, 1'b1);
        rw0 = rw_cnt;
        instr(4'hF, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1);
        check("cmp_flags", dut_flags(), flags(1, 0, 0));
        check("cmp_rw_pulses", 8'(rw_cnt - rw0), 8'd0);
        rd(2'd1, v);
        check("cmp_r1_kept", v, 8'h10);
        instr(4'h9, 2'd3, 2'd1, 1'b1, 8'hAA, 1'b1);
        check("jz_res_hold", alu_result, 8'h00);
        check("jz_flags_hold", dut_flags(), flags(1, 0, 0));

        // SHL R3=81 ; SHR R3=01
        instr(4'h0, 2'd3, 2'd0, 1'b1, 8'h81, 1'b1);
        instr(4'h6, 2'd3, 2'd0, 1'b0, 8'h00, 1'b1);
        check("shl_res", alu_result, 8'h02);
        check("shl_flags", dut_flags(), flags(0, 1, 0));
        instr(4'h0, 2'd3, 2'd0, 1'b1, 8'h01, 1'b1);
        instr(4'h7, 2'd3, 2'd0, 1'b0, 8'h00, 1'b1);
        check("shr_res", alu_result, 8'h00);
        check("shr_flags", dut_flags(), flags(1, 1, 0));

        // Reset asserted mid-WRITEBACK of ADD R0, R1 (50 + 05)
        instr(4'h0, 2'd0, 2'd0, 1'b1, 8'h50, 1'b1);
        instr(4'h0, 2'd1, 2'd0, 1'b1, 8'h05, 1'b1);
        step(ST_FETCH, 4'h1, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
        step(ST_DEC, 4'h1, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
        step(ST_EXEC, 4'h1, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
        current_state    = ST_WB;
        update_registers = 1'b1;
        dbg_sel          = 2'd0;
        #1;
        check("pre_reset_res", alu_result, 8'h55);
        check("pre_reset_rw", {7'b0, reg_write}, 8'h01);
        chk_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_reset_res", alu_result, 8'h00);
        check("async_reset_flags", dut_flags(), 8'h00);
        check("async_reset_rw", {7'b0, reg_write}, 8'h00);
        check("async_reset_r0", dbg_data, 8'h00);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) step(ST_FETCH, 4'h1, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1);
        check("post_reset_res", alu_result, 8'h00);
        rd(2'd0, v);
        check("post_reset_r0", v, 8'h00);

        // Randomized instruction stream with stray cycles in arbitrary states.
        repeat (400) begin
            if ($urandom_range(0, 4) == 0)
                step(3'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom), 8'($urandom), 1'($urandom));
            else
                instr(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                      8'($urandom), ($urandom_range(0, 7) != 0));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
